// File: rtl/mac_sequencer.sv
// Multiply-accumulate sequencer: streams operand pairs into an external 8x8 multiplier
// and accumulates the products into a saturating accumulator with a valid/ready result port.
module mac_sequencer #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [ACC_W-1:0] acc;
    logic             pend;
    logic             accept;
    logic [ACC_W:0]   sum;

    always_comb begin
        accept = in_valid & in_ready & (state == RUN);
        sum    = {1'b0, acc} + {{(ACC_W-15){1'b0}}, mul_prod};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            pend      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // The product of the previous accept is on mul_prod now; a new accept re-arms pend.
            pend <= accept;
            if (pend) begin
                if (sum[ACC_W]) begin
                    acc     <= '1;
                    out_ovf <= 1'b1;
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end
            if (accept) begin
                mul_a     <= in_a;
                mul_b     <= in_b;
                remaining <= remaining - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        acc     <= '0;
                        out_ovf <= 1'b0;
                        if (len != '0) begin
                            state     <= RUN;
                            remaining <= len;
                            in_ready  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_acc   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (accept && remaining == CNT_W'(1)) begin
                        in_ready <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_acc   <= acc;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: 24-bit and 16-bit accumulator instances share stimulus and
// are compared against a sum-of-products reference clamped to each accumulator width.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [7:0]  len, in_a, in_b;
    logic        rdy24, rdy16, ov24, ov16, ovf24, ovf16, busy24, busy16;
    logic [7:0]  ma24, mb24, ma16, mb16;
    logic [15:0] mp24, mp16;
    logic [23:0] acc24;
    logic [15:0] acc16;

    int total = 0;
    int bad   = 0;
    logic [7:0] pa [256];
    logic [7:0] pb [256];

    always #5 clk = ~clk;

    assign mp24 = 16'(ma24) * 16'(mb24);
    assign mp16 = 16'(ma16) * 16'(mb16);

    mac_sequencer #(.ACC_W(24), .CNT_W(8)) dut24 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(rdy24), .in_a(in_a), .in_b(in_b),
        .mul_a(ma24), .mul_b(mb24), .mul_prod(mp24),
        .out_valid(ov24), .out_ready(out_ready), .out_acc(acc24),
        .out_ovf(ovf24), .busy(busy24)
    );

    mac_sequencer #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
        .mul_a(ma16), .mul_b(mb16), .mul_prod(mp16),
        .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16),
        .out_ovf(ovf16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete job using pa/pb[0..n-1]; expectations come from the plain sum of products.
    task automatic run_job(input int n, input int gap_pct, input bit use_pat,
                           input logic [31:0] vpat, input int stall, input bit inj_start);
        longint      sum = 0;
        int          idx = 0;
        int          c = 0;
        int          w = 0;
        logic [23:0] e24, hold;
        logic [15:0] e16;
        bit          v;
        for (int i = 0; i < n; i++) sum += longint'(pa[i]) * longint'(pb[i]);
        e24 = (sum > 64'hFFFFFF) ? 24'hFFFFFF : sum[23:0];
        e16 = (sum > 64'hFFFF)   ? 16'hFFFF   : sum[15:0];

        start = 1'b1; len = n[7:0];
        cyc();
        start = 1'b0; len = 8'($urandom);
        check("busy_start", busy24, 1);
        while (idx < n && c < 2000) begin
            check("in_ready_run", {rdy24, rdy16}, 2'b11);
            v = use_pat ? vpat[c % 32] : ($urandom_range(99) >= gap_pct);
            if (inj_start && idx == 1) begin start = 1'b1; len = 8'd9; end
            in_valid = v; in_a = pa[idx]; in_b = pb[idx];
            cyc();
            start = 1'b0;
            if (v) idx++;
            c++;
        end
        if (idx < n) check("run_timeout", idx, n);
        in_valid = 1'($urandom_range(1)); in_a = 8'($urandom); in_b = 8'($urandom);
        while (!ov24 && w < 50) begin
            check("in_ready_drain", {rdy24, rdy16}, 2'b00);
            cyc();
            w++;
        end
        check("latency", w, (n > 0) ? 2 : 0);
        check("valid16", ov16, 1);
        check("acc24", acc24, e24);
        check("acc16", acc16, e16);
        check("ovf24", ovf24, sum > 64'hFFFFFF);
        check("ovf16", ovf16, sum > 64'hFFFF);
        check("busy_done", busy24, 1);
        hold = acc24;
        repeat (stall) begin
            out_ready = 1'b0;
            cyc();
            check("hold_valid", ov24, 1);
            check("hold_acc", acc24, hold);
        end
        out_ready = 1'b1; start = 1'b1; len = 8'd5;
        cyc();
        out_ready = 1'b0; start = 1'b0;
        check("valid_drop", ov24, 0);
        check("busy_drop", busy24, 0);
        check("acc_keep", acc24, hold);
        cyc();
        check("start_at_done_ignored", {busy24, busy16}, 2'b00);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        len = '0; in_a = '0; in_b = '0;
        cyc(); cyc();
        check("rst_outputs", {ov24, ovf24, busy24, rdy24}, 4'b0000);
        check("rst_acc", acc24, 0);
        check("rst_mul", {ma24, mb24}, 0);
        reset = 1'b0;
        cyc();

        // basic: 12 + 30 + 65025
        pa[0] = 3; pb[0] = 4; pa[1] = 5; pb[1] = 6; pa[2] = 255; pb[2] = 255;
        run_job(3, 0, 1'b0, 0, 0, 1'b0);
        check("basic_value", acc24, 65067);

        run_job(0, 0, 1'b0, 0, 2, 1'b0);

        for (int i = 0; i < 4; i++) begin pa[i] = 10; pb[i] = 10; end
        run_job(4, 0, 1'b1, 32'b1011001, 5, 1'b0);
        check("stall_value", acc24, 400);

        pa[0] = 255; pb[0] = 255; pa[1] = 255; pb[1] = 255; pa[2] = 1; pb[2] = 1;
        run_job(3, 0, 1'b0, 0, 0, 1'b0);
        check("sat_value16", acc16, 65535);
        pa[0] = 2; pb[0] = 3;
        run_job(1, 0, 1'b0, 0, 0, 1'b0);
        check("after_sat16", {ovf16, acc16}, {1'b0, 16'd6});

        pa[0] = 7; pb[0] = 8; pa[1] = 9; pb[1] = 9;
        run_job(2, 0, 1'b0, 0, 0, 1'b1);
        check("ign_start_value", acc24, 137);

        for (int i = 0; i < 255; i++) begin pa[i] = 255; pb[i] = 255; end
        run_job(255, 10, 1'b0, 0, 1, 1'b0);

        for (int j = 0; j < 20; j++) begin
            int n;
            n = $urandom_range(16);
            for (int i = 0; i < n; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
            run_job(n, 30, 1'b0, 0, $urandom_range(3), 1'($urandom_range(1)));
        end

        // reset in the middle of a 5-pair job, applied between clock edges
        start = 1'b1; len = 8'd5;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd20; in_b = 8'd30;
        cyc();
        in_a = 8'd40; in_b = 8'd50;
        cyc();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ctrl", {ov24, ovf24, busy24, rdy24}, 4'b0000);
        check("mid_rst_acc", acc24, 0);
        check("mid_rst_mul", {ma24, mb24}, 0);
        #1 reset = 1'b0;
        cyc();
        pa[0] = 12; pb[0] = 12;
        run_job(1, 0, 1'b0, 0, 0, 1'b0);
        check("post_rst_value", acc24, 144);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
